scan_link_receiver: RTL
=======================

Name: scan_link_receiver

Overview:
- Downstream stage of the scanner serial output: deserializes the scanner's bit stream (LSB first, 8-bit frames), decodes command frames and captures data frames.
- Produces single-cycle event pulses and a data byte stream for the transfer/buffer controller.
- Flags malformed traffic: unknown command codes and mid-frame stalls.

Parameters:
- GAP_TIMEOUT, 16: consecutive idle cycles inside a partial frame before the frame is aborted.
- DCOUNT_W, 8: width of the data-byte counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- serialValid  in  1  bit strobe; serialData is sampled on each posedge where this is 1.
- serialData  in  1  serial bit, LSB of each frame first.
- cmdValid  out  1  one-cycle pulse: a command frame completed.
- cmdCode  out  8  last completed command byte; held between frames.
- readyToTransfer  out  1  pulse on command 2 (scanner at 80%).
- startScanning  out  1  pulse on command 3 (scanner at 90%).
- bufferFull  out  1  pulse on command 4 (scanner at 100%).
- dataValid  out  1  one-cycle pulse: a data byte completed.
- dataByte  out  8  last completed data byte; held.
- frameError  out  1  one-cycle pulse: unknown command or gap timeout.
- dataCount  out  DCOUNT_W  data bytes received since reset; saturates at all-ones.
- busy  out  1  high while a frame is partially received or a data frame is expected.

Behaviour:
- Reset (asynchronous, immediate): state=CMD_SHIFT, bit counter=0, shift register=0, gap counter=0. All pulse outputs 0; cmdCode=0, dataByte=0, dataCount=0, busy=0.
- Shift: on each posedge with serialValid=1, serialData goes into shift bit [bitCount] and bitCount increments (3-bit, wraps 7->0). The gap counter clears.
- Frame completion: the edge that samples bit 7 completes the frame. Outputs are registered, so the pulse is high for exactly the following cycle (latency 1 cycle after the last bit edge). The shift register clears for the next frame.
- FSM states:
  - CMD_SHIFT: on completion, cmdCode<=byte and cmdValid=1.
    - 2 -> readyToTransfer; 3 -> startScanning; 4 -> bufferFull. Stay in CMD_SHIFT.
    - 7 -> go to DATA_SHIFT. No decoded pulse other than cmdValid.
    - Any other code -> frameError pulse as well as cmdValid. Stay in CMD_SHIFT.
  - DATA_SHIFT: on completion, dataByte<=byte, dataValid=1, dataCount+1 (saturating), return to CMD_SHIFT. Data bytes are never decoded as commands; e.g. byte 0x02 gives no readyToTransfer.
- busy = (bitCount!=0) or state==DATA_SHIFT.
- Gap timeout: the gap counter increments on each cycle with serialValid=0 while busy=1.
  - When it reaches GAP_TIMEOUT, the partial frame is discarded: bitCount=0, shift register=0, state=CMD_SHIFT, frameError pulses once, gap counter clears.
  - serialValid=1 in the same cycle the counter would reach the limit wins: the bit is accepted and there is no timeout.
  - No timeout while idle (busy=0).
- Back-to-back frames with no idle cycle between them are legal; bit 0 of the next frame can be sampled on the cycle the previous frame's pulse is high.
- Only one of cmdValid/dataValid is high in any cycle. frameError may coincide with cmdValid (unknown code) but never with dataValid.
- Reset mid-frame: the partial frame is lost with no pulse; the FSM restarts in CMD_SHIFT.

Decomposition:
- Shared package scan_link_pkg:
  - command constants CMD_READY_XFER=8'd2, CMD_START_SCAN=8'd3, CMD_FULL=8'd4, CMD_DATA=8'd7;
  - FRAME_W=8;
  - FSM state encoding.
- The scanner side imports the same constants.
- One sub-module, serial_shift_in: bit counter, shift register, gap counter, and a frameDone/frameByte/timeout output.
- The top level holds the decode FSM, the pulse registers and dataCount.

Test Plan:
- Reset, then send byte 0x02 LSB first on 8 consecutive valid cycles -> cmdValid and readyToTransfer high for exactly 1 cycle after the 8th bit; cmdCode=0x02; busy back to 0.
- Send 0x07 then data 0xA5 back-to-back -> cmdValid with cmdCode=0x07, then dataValid with dataByte=0xA5; dataCount=1; no startScanning or bufferFull pulses.
- Send 0x07 then data 0x03 -> dataValid with dataByte=0x03; startScanning stays 0 (data is not decoded as a command).
- Send 0x05 -> cmdValid and frameError in the same cycle; no decoded pulse; the FSM stays in CMD_SHIFT.
- Send 4 bits, then hold serialValid=0 for 16 cycles -> single frameError pulse. A following 0x04 frame then gives bufferFull, proving the partial frame was discarded.
- Assert rst for 1 cycle mid-data-frame, and separately send 260 data frames -> all outputs at reset values immediately on rst; dataCount saturates at 255.

Source files
------------

// File: rtl/scan_link_pkg.sv
// Shared definitions for the scanner serial link.
// The scanner transmitter and the link receiver both import this package,
// so they agree on the command byte values and the frame width.
// Contents: command byte constants, the frame width and the receiver FSM
// state encoding.
package scan_link_pkg;

  localparam int FRAME_W = 8;

  localparam logic [FRAME_W-1:0] CMD_READY_XFER = 8'd2;  // scanner at 80%
  localparam logic [FRAME_W-1:0] CMD_START_SCAN = 8'd3;  // scanner at 90%
  localparam logic [FRAME_W-1:0] CMD_FULL       = 8'd4;  // scanner at 100%
  localparam logic [FRAME_W-1:0] CMD_DATA       = 8'd7;  // next frame is data

  // Receiver decode FSM: CMD_SHIFT decodes command frames. DATA_SHIFT
  // captures exactly one data frame and then returns to CMD_SHIFT.
  typedef enum logic {
    ST_CMD_SHIFT  = 1'b0,
    ST_DATA_SHIFT = 1'b1
  } scan_state_e;

endpackage

// File: rtl/scan_link_receiver_if.sv
// Bundle of signals between the scanner serial output, the link receiver
// and the transfer/buffer controller.
//   serialValid/serialData : bit strobe and serial bit (LSB of each frame first)
//   cmdValid/cmdCode       : command frame completed / last command byte
//   readyToTransfer, startScanning, bufferFull : decoded command pulses
//   dataValid/dataByte     : data frame completed / last data byte
//   frameError             : unknown command or mid-frame stall
//   dataCount              : saturating count of data bytes
//   busy                   : frame in progress or data frame expected
// Handshake: there is no backpressure. A serial bit is consumed on every
// posedge where serialValid is 1. Every *Valid and event output is a
// one-cycle pulse that the consumer must take in that cycle. The byte and
// code outputs hold their value until the next frame of the same kind.
// Modports: slave = the receiver, master = the environment around it.
interface scan_link_receiver_if #(
  parameter int DCOUNT_W = 8
);
  logic                serialValid;
  logic                serialData;
  logic                cmdValid;
  logic [7:0]          cmdCode;
  logic                readyToTransfer;
  logic                startScanning;
  logic                bufferFull;
  logic                dataValid;
  logic [7:0]          dataByte;
  logic                frameError;
  logic [DCOUNT_W-1:0] dataCount;
  logic                busy;

  modport slave (
    input  serialValid, serialData,
    output cmdValid, cmdCode, readyToTransfer, startScanning, bufferFull,
           dataValid, dataByte, frameError, dataCount, busy
  );

  modport master (
    output serialValid, serialData,
    input  cmdValid, cmdCode, readyToTransfer, startScanning, bufferFull,
           dataValid, dataByte, frameError, dataCount, busy
  );
endinterface

// File: rtl/serial_shift_in.sv
// Serial-to-parallel front end of the link receiver.
// Gathers LSB-first bits into FRAME_W-bit frames. It also aborts a
// partially received frame after GAP_TIMEOUT consecutive idle cycles while
// busy.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   bit_valid      : sample bit_data on this edge
//   bit_data       : serial bit
//   data_expected  : decoder is waiting for a data frame (counts as busy)
//   frame_done     : this edge samples the last bit of a frame (combinational)
//   frame_byte     : completed frame including the bit sampled this edge
//   timeout        : this edge aborts the partial frame (combinational)
//   partial        : some bits of a frame have been received
module serial_shift_in
  import scan_link_pkg::*;
#(
  parameter int GAP_TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_valid,
  input  logic               bit_data,
  input  logic               data_expected,
  output logic               frame_done,
  output logic [FRAME_W-1:0] frame_byte,
  output logic               timeout,
  output logic               partial
);

  localparam int CNT_W = $clog2(FRAME_W);
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);

  logic [CNT_W-1:0]   bit_count;
  logic [FRAME_W-1:0] shift_q;
  logic [GAP_W-1:0]   gap_q;
  logic               busy;

  assign partial = (bit_count != '0);
  assign busy    = partial || data_expected;

  assign frame_done = bit_valid && (bit_count == CNT_W'(FRAME_W - 1));

  // On completion the top bit of shift_q is still clear, so the final bit
  // is merged straight into the top position of the output byte.
  always_comb begin
    frame_byte            = shift_q;
    frame_byte[FRAME_W-1] = bit_data;
  end

  // A valid bit on the edge where the limit would be reached wins.
  assign timeout = !bit_valid && busy && (gap_q == GAP_W'(GAP_TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_count <= '0;
      shift_q   <= '0;
      gap_q     <= '0;
    end else if (bit_valid) begin
      gap_q     <= '0;
      bit_count <= bit_count + 1'b1;
      if (frame_done) begin
        shift_q <= '0;
      end else begin
        shift_q[bit_count] <= bit_data;
      end
    end else if (timeout) begin
      bit_count <= '0;
      shift_q   <= '0;
      gap_q     <= '0;
    end else if (busy) begin
      gap_q <= gap_q + 1'b1;
    end else begin
      gap_q <= '0;
    end
  end

endmodule

// File: rtl/scan_link_receiver.sv
// Scanner serial link receiver.
// Deserializes the scanner bit stream, decodes command frames into event
// pulses and captures the data frame that follows a CMD_DATA command.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   link      : slave side of scan_link_receiver_if (serial input, pulses,
//               held bytes, dataCount, busy)
//   state_dbg : current decode FSM state
module scan_link_receiver
  import scan_link_pkg::*;
#(
  parameter int GAP_TIMEOUT = 16,
  parameter int DCOUNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  scan_link_receiver_if.slave  link,
  output scan_state_e          state_dbg
);

  logic               frame_done;
  logic [FRAME_W-1:0] frame_byte;
  logic               timeout;
  logic               partial;

  scan_state_e         state;
  logic                cmd_valid;
  logic [7:0]          cmd_code;
  logic                ready_to_transfer;
  logic                start_scanning;
  logic                buffer_full;
  logic                data_valid;
  logic [7:0]          data_byte;
  logic                frame_error;
  logic [DCOUNT_W-1:0] data_count;

  serial_shift_in #(
    .GAP_TIMEOUT (GAP_TIMEOUT)
  ) u_shift (
    .clk           (clk),
    .rst           (rst),
    .bit_valid     (link.serialValid),
    .bit_data      (link.serialData),
    .data_expected (state == ST_DATA_SHIFT),
    .frame_done    (frame_done),
    .frame_byte    (frame_byte),
    .timeout       (timeout),
    .partial       (partial)
  );

  // Decode FSM with registered pulses: each pulse is high for exactly the
  // cycle after the edge that sampled the last bit of its frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ST_CMD_SHIFT;
      cmd_valid         <= 1'b0;
      cmd_code          <= '0;
      ready_to_transfer <= 1'b0;
      start_scanning    <= 1'b0;
      buffer_full       <= 1'b0;
      data_valid        <= 1'b0;
      data_byte         <= '0;
      frame_error       <= 1'b0;
      data_count        <= '0;
    end else begin
      cmd_valid         <= 1'b0;
      ready_to_transfer <= 1'b0;
      start_scanning    <= 1'b0;
      buffer_full       <= 1'b0;
      data_valid        <= 1'b0;
      frame_error       <= 1'b0;
      if (frame_done) begin
        case (state)
          ST_CMD_SHIFT: begin
            cmd_valid <= 1'b1;
            cmd_code  <= frame_byte;
            case (frame_byte)
              CMD_READY_XFER: ready_to_transfer <= 1'b1;
              CMD_START_SCAN: start_scanning    <= 1'b1;
              CMD_FULL:       buffer_full       <= 1'b1;
              CMD_DATA:       state             <= ST_DATA_SHIFT;
              default:        frame_error       <= 1'b1;
            endcase
          end
          ST_DATA_SHIFT: begin
            data_valid <= 1'b1;
            data_byte  <= frame_byte;
            if (data_count != '1) begin
              data_count <= data_count + 1'b1;
            end
            state <= ST_CMD_SHIFT;
          end
          default: state <= ST_CMD_SHIFT;
        endcase
      end else if (timeout) begin
        // Partial frame (or awaited data frame) abandoned.
        frame_error <= 1'b1;
        state       <= ST_CMD_SHIFT;
      end
    end
  end

  assign link.cmdValid        = cmd_valid;
  assign link.cmdCode         = cmd_code;
  assign link.readyToTransfer = ready_to_transfer;
  assign link.startScanning   = start_scanning;
  assign link.bufferFull      = buffer_full;
  assign link.dataValid       = data_valid;
  assign link.dataByte        = data_byte;
  assign link.frameError      = frame_error;
  assign link.dataCount       = data_count;
  assign link.busy            = partial || (state == ST_DATA_SHIFT);
  assign state_dbg            = state;

endmodule
